// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Recovers the eight displayed characters from a multiplexed, active-low
// 7-segment scan bus. Each strobe dwell is sampled until it has been steady
// long enough. Its glyph is decoded to a hex nibble and collected into a
// shadow frame. After position 7 the frame is handed to the consumer
// through a valid/ready output register.
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples required before a position
//                  is latched (intended to be >= 1)
//
// Ports
//   clk           rising-edge system clock
//   rst           asynchronous, active-high reset
//   digit         scan strobe, active-low one-hot (bit i low = position i)
//   segment_data  active-low segments, bit0=a .. bit6=g, bit7=dp
//   frame_data    decoded nibbles, position i in bits [4i+3:4i]
//   frame_dp      decimal points, bit i set when dp lit at position i
//   frame_valid   frame_data/frame_dp hold a complete frame
//   frame_ready   consumer accepts the presented frame
//   overflow      sticky: a completed frame was dropped (output still full)
//   decode_err    sticky: an unrecognised glyph was latched
//
// Build option
//   SEG_DECODE_ERR_EN  when defined, unrecognised glyphs set decode_err.
//                      Otherwise decode_err is tied low. In both builds such
//                      a glyph decodes to nibble 0.
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  digit,
  input  logic [7:0]  segment_data,
  output logic [31:0] frame_data,
  output logic [7:0]  frame_dp,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overflow,
  output logic        decode_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, SETTLE, LATCH, WAIT_NEXT} state_t;

  state_t        state;
  state_t        state_next;

  logic [7:0]    dig_q;
  logic [7:0]    seg_q;
  logic [CW-1:0] cnt;
  logic [2:0]    exp_pos;
  logic [7:0]    lat_dig;
  logic [7:0]    lat_seg;
  logic [31:0]   shadow_data;
  logic [7:0]    shadow_dp;

  logic          sample_same;
  logic          sample_blank;
  logic          stable;
  logic          in_order;
  logic          hunt_en;
  logic          capture_en;
  logic          latch_en;
  logic          frame_done;
  logic [3:0]    lat_nib;
  logic [31:0]   full_data;
  logic [7:0]    full_dp;

  // True when exactly one strobe line is pulled low.
  function automatic logic is_single(input logic [7:0] d);
    return $onehot(~d);
  endfunction

  // Index of the low strobe bit. Only meaningful when is_single() holds.
  function automatic logic [2:0] pos_of(input logic [7:0] d);
    logic [2:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (!d[i]) p = 3'(i);
    end
    return p;
  endfunction

  // Active-high glyph to hex nibble. Unknown patterns fall back to 0.
  function automatic logic [3:0] glyph_nibble(input logic [6:0] g);
    case (g)
      7'h3F: return 4'h0;
      7'h06: return 4'h1;
      7'h5B: return 4'h2;
      7'h4F: return 4'h3;
      7'h66: return 4'h4;
      7'h6D: return 4'h5;
      7'h7D: return 4'h6;
      7'h07: return 4'h7;
      7'h7F: return 4'h8;
      7'h6F: return 4'h9;
      7'h77: return 4'hA;
      7'h7C: return 4'hB;
      7'h39: return 4'hC;
      7'h5E: return 4'hD;
      7'h79: return 4'hE;
      7'h71: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

`ifdef SEG_DECODE_ERR_EN
  // Recognises the sixteen legal glyphs. Used only for error flagging.
  function automatic logic glyph_known(input logic [6:0] g);
    case (g)
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  // The stability compare checks the incoming sample against the registered
  // one. The count therefore describes how long the registered copy has
  // been steady. A blank strobe never accumulates stability.
  assign sample_same  = ({digit, segment_data} == {dig_q, seg_q});
  assign sample_blank = !is_single(digit);
  assign stable       = (cnt == CNT_MAX) && is_single(dig_q);
  assign in_order     = (pos_of(dig_q) == exp_pos);

  // Input register and saturating stability counter. Saturation keeps a
  // long dwell from wrapping back into a second latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= 8'hFF;
      seg_q <= 8'hFF;
      cnt   <= '0;
    end else begin
      dig_q <= digit;
      seg_q <= segment_data;
      if (sample_blank || !sample_same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // Next-state logic. A frame only begins on position 0. Once a position
  // is latched, WAIT_NEXT blocks re-latching until the strobe moves on.
  always_comb begin
    state_next = state;
    case (state)
      HUNT:      if (dig_q == 8'hFE) state_next = SETTLE;
      SETTLE:    if (stable) state_next = in_order ? LATCH : HUNT;
      LATCH:     state_next = (exp_pos == 3'd7) ? HUNT : WAIT_NEXT;
      WAIT_NEXT: if (dig_q != lat_dig) state_next = SETTLE;
      default:   state_next = HUNT;
    endcase
  end

  // FSM outputs. The sample is captured on the SETTLE->LATCH decision so
  // the LATCH cycle is immune to the strobe moving underneath it.
  always_comb begin
    hunt_en    = (state == HUNT);
    capture_en = (state == SETTLE) && stable && in_order;
    latch_en   = (state == LATCH);
  end

  assign lat_nib    = glyph_nibble(~lat_seg[6:0]);
  assign frame_done = latch_en && (exp_pos == 3'd7);

  // Position 7 bypasses the shadow, so the merged frame is ready in the
  // same cycle LATCH completes.
  always_comb begin
    full_data        = shadow_data;
    full_data[31:28] = lat_nib;
    full_dp          = shadow_dp;
    full_dp[7]       = ~lat_seg[7];
  end

  // Shadow frame assembly. Returning to HUNT throws away any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_pos     <= '0;
      lat_dig     <= 8'hFF;
      lat_seg     <= 8'hFF;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      if (hunt_en) begin
        exp_pos     <= '0;
        shadow_data <= '0;
        shadow_dp   <= '0;
      end
      if (capture_en) begin
        lat_dig <= dig_q;
        lat_seg <= seg_q;
      end
      if (latch_en) begin
        shadow_data[{exp_pos, 2'b00} +: 4] <= lat_nib;
        shadow_dp[exp_pos]                 <= ~lat_seg[7];
        exp_pos                            <= exp_pos + 3'd1;
      end
    end
  end

  // Output handshake. A completed frame loads when the output is empty or
  // being accepted in the same cycle. Otherwise the frame is dropped and
  // the event is remembered in overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_data  <= '0;
      frame_dp    <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (frame_done) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= full_data;
          frame_dp    <= full_dp;
          frame_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_DECODE_ERR_EN
  // Sticky flag for any glyph outside the hex set reaching LATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      decode_err <= 1'b0;
    else if (latch_en && !glyph_known(~lat_seg[6:0]))
      decode_err <= 1'b1;
  end
`else
  assign decode_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Directed and randomized checks of seg_scan_decoder. Scan patterns are
// built from a glyph table. Expected frames are computed by looking each
// segment pattern back up in that table.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  digit;
  logic [7:0]  segment_data;
  logic [31:0] frame_data;
  logic [7:0]  frame_dp;
  logic        frame_valid;
  logic        frame_ready;
  logic        overflow;
  logic        decode_err;

  int checks = 0;
  int errors = 0;

  // Active-high glyphs for hex digits 0..F.
  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Segment bytes of the frame currently being driven.
  logic [7:0] fseg [8];

  logic [31:0] exp_a_data, exp_b_data;
  logic [7:0]  exp_a_dp,   exp_b_dp;
  logic        exp_err;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .digit(digit), .segment_data(segment_data),
    .frame_data(frame_data), .frame_dp(frame_dp), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .overflow(overflow), .decode_err(decode_err)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare one observed value against the model's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one display position for a given dwell.
  task automatic applyStimulus(input int pos, input logic [7:0] seg, input int dwell);
    digit        = ~(8'h01 << pos);
    segment_data = seg;
    step(dwell);
  endtask

  // Drive a blank strobe for n cycles.
  task automatic applyBlank(input int n);
    digit        = 8'hFF;
    segment_data = 8'hFF;
    if (n > 0) step(n);
  endtask

  // Segment byte a display would drive for a hex value and dp.
  function automatic logic [7:0] seg_for(input int nib, input bit dp);
    return {~dp, ~glyphs[nib]};
  endfunction

  // Reference decode: table lookup, anything unknown reads as 0.
  function automatic logic [3:0] model_nibble(input logic [7:0] seg);
    for (int n = 0; n < 16; n++)
      if (glyphs[n] == ~seg[6:0]) return 4'(n);
    return 4'h0;
  endfunction

  function automatic logic [31:0] model_data();
    logic [31:0] d = '0;
    for (int i = 0; i < 8; i++) d[4*i +: 4] = model_nibble(fseg[i]);
    return d;
  endfunction

  function automatic logic [7:0] model_dp();
    logic [7:0] d = '0;
    for (int i = 0; i < 8; i++) d[i] = ~fseg[i][7];
    return d;
  endfunction

  task automatic random_frame();
    for (int i = 0; i < 8; i++)
      fseg[i] = seg_for(int'($urandom_range(15, 0)), bit'($urandom_range(1, 0)));
  endtask

  // Scan the whole frame once, then blank.
  task automatic send_frame(input int dlo, input int dhi, input int gap);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i, fseg[i], int'($urandom_range(dhi, dlo)));
      if (gap > 0) applyBlank(int'($urandom_range(gap, 0)));
    end
    applyBlank(0);
  endtask

  // Bounded wait for frame_valid. The caller's check reports any timeout.
  task automatic wait_valid(input int budget);
    int n = 0;
    while (!frame_valid && n < budget) begin
      step(1);
      n++;
    end
  endtask

  // Accept the presented frame for one cycle.
  task automatic accept();
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
  endtask

  // Directed scenarios followed by randomized frames.
  initial begin
`ifdef SEG_DECODE_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1; digit = 8'hFF; segment_data = 8'hFF; frame_ready = 1'b0;
    step(3);
    checkOutput("reset_data", frame_data, 32'h0);
    checkOutput("reset_dp", {24'h0, frame_dp}, 32'h0);
    checkOutput("reset_valid", {31'h0, frame_valid}, 32'h0);
    checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("reset_decode_err", {31'h0, decode_err}, 32'h0);
    rst = 1'b0;
    step(2);

    // Full frame 0..7 with latency measured on position 7.
    fseg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    for (int i = 0; i < 7; i++) applyStimulus(i, fseg[i], 10);
    digit = 8'h7F; segment_data = fseg[7];
    step(S + 1);
    checkOutput("latency_early", {31'h0, frame_valid}, 32'h0);
    step(1);
    checkOutput("latency_valid", {31'h0, frame_valid}, 32'h1);
    step(10 - S - 2);
    applyBlank(3);
    checkOutput("full_data", frame_data, 32'h76543210);
    checkOutput("full_dp", {24'h0, frame_dp}, 32'h0);
    checkOutput("full_model", frame_data, model_data());
    accept();
    checkOutput("accept_drop", {31'h0, frame_valid}, 32'h0);

    // Glitch: position 0 too short, so the following positions form no frame.
    applyStimulus(0, 8'hC0, 2);
    applyBlank(6);
    for (int i = 1; i < 8; i++) applyStimulus(i, fseg[i], 8);
    applyBlank(10);
    checkOutput("glitch_no_frame", {31'h0, frame_valid}, 32'h0);

    // Frame A held. Frame B completes in the same cycle A is accepted.
    random_frame();
    exp_a_data = model_data(); exp_a_dp = model_dp();
    send_frame(10, 10, 0);
    wait_valid(12);
    checkOutput("a_valid", {31'h0, frame_valid}, 32'h1);
    checkOutput("a_data", frame_data, exp_a_data);
    random_frame();
    fseg[0] = seg_for(int'(~exp_a_data[3:0]), 1'b0);
    exp_b_data = model_data(); exp_b_dp = model_dp();
    for (int i = 0; i < 7; i++) applyStimulus(i, fseg[i], 8);
    digit = 8'h7F; segment_data = fseg[7];
    step(S + 1);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    checkOutput("swap_valid", {31'h0, frame_valid}, 32'h1);
    checkOutput("swap_data", frame_data, exp_b_data);
    checkOutput("swap_dp", {24'h0, frame_dp}, {24'h0, exp_b_dp});
    checkOutput("swap_no_overflow", {31'h0, overflow}, 32'h0);
    step(3);
    applyBlank(2);

    // Backpressure: frame C arrives while B is still pending.
    random_frame();
    send_frame(8, 8, 0);
    step(S + 4);
    checkOutput("bp_overflow", {31'h0, overflow}, 32'h1);
    checkOutput("bp_valid_held", {31'h0, frame_valid}, 32'h1);
    checkOutput("bp_data_held", frame_data, exp_b_data);
    accept();
    checkOutput("bp_release", {31'h0, frame_valid}, 32'h0);

    // Out-of-order strobe discards the partial frame.
    applyStimulus(0, seg_for(9, 0), 10);
    applyStimulus(1, seg_for(9, 0), 10);
    applyStimulus(3, seg_for(9, 0), 10);
    applyBlank(3);
    checkOutput("ooo_no_frame", {31'h0, frame_valid}, 32'h0);
    random_frame();
    send_frame(9, 9, 1);
    wait_valid(12);
    checkOutput("ooo_data", frame_data, model_data());
    checkOutput("ooo_dp", {24'h0, frame_dp}, {24'h0, model_dp()});
    accept();

    // Invalid glyph at position 3.
    random_frame();
    fseg[3] = 8'hFF;
    send_frame(8, 8, 0);
    wait_valid(12);
    checkOutput("bad_glyph_data", frame_data, model_data());
    checkOutput("bad_glyph_nibble", {28'h0, frame_data[15:12]}, 32'h0);
    checkOutput("bad_glyph_err", {31'h0, decode_err}, {31'h0, exp_err});

    // Reset after position 4 while outputs are non-zero.
    random_frame();
    for (int i = 0; i < 5; i++) applyStimulus(i, fseg[i], 8);
    rst = 1'b1;
    #1;
    checkOutput("midrst_data", frame_data, 32'h0);
    checkOutput("midrst_dp", {24'h0, frame_dp}, 32'h0);
    checkOutput("midrst_valid", {31'h0, frame_valid}, 32'h0);
    checkOutput("midrst_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("midrst_decode_err", {31'h0, decode_err}, 32'h0);
    step(2);
    rst = 1'b0;
    for (int i = 5; i < 8; i++) applyStimulus(i, fseg[i], 8);
    applyBlank(10);
    checkOutput("midrst_no_tail", {31'h0, frame_valid}, 32'h0);
    random_frame();
    send_frame(8, 8, 0);
    wait_valid(12);
    checkOutput("midrst_next_data", frame_data, model_data());
    checkOutput("midrst_next_dp", {24'h0, frame_dp}, {24'h0, model_dp()});
    accept();

    // Randomized frames with varied dwell and blank gaps.
    for (int f = 0; f < 16; f++) begin
      random_frame();
      send_frame(S, S + 6, 2);
      wait_valid(16);
      checkOutput($sformatf("rand%0d_valid", f), {31'h0, frame_valid}, 32'h1);
      checkOutput($sformatf("rand%0d_data", f), frame_data, model_data());
      checkOutput($sformatf("rand%0d_dp", f), {24'h0, frame_dp}, {24'h0, model_dp()});
      accept();
      checkOutput($sformatf("rand%0d_drop", f), {31'h0, frame_valid}, 32'h0);
    end
    checkOutput("final_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("final_decode_err", {31'h0, decode_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: number of consecutive identical samples of digit and segment_data needed before a digit is latched.
REQ-002 SHALL have port clk, input, 1: system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port digit, input, 8: scan strobe, active-low one-hot; bit i low selects display position i.
REQ-005 SHALL have port segment_data, input, 8: active-low segments; bit0=a through bit6=g, bit7=dp.
REQ-006 SHALL have port frame_data, output, 32: decoded nibbles; position i maps to bits [4i+3:4i].
REQ-007 SHALL have port frame_dp, output, 8: decoded decimal points; bit i is 1 when dp is lit at position i.
REQ-008 SHALL have port frame_valid, output, 1: frame_data and frame_dp hold a complete frame.
REQ-009 SHALL have port frame_ready, input, 1: consumer accepts the frame.
REQ-010 SHALL have port overflow, output, 1: sticky flag; a complete frame was dropped.
REQ-011 SHALL have port decode_err, output, 1: sticky flag; an unrecognised glyph was latched.

Function
REQ-012 SHALL register digit and segment_data once at input; all decoding uses the registered copies.
REQ-013 SHALL treat a digit value that does not have exactly one low bit as blank, and SHALL clear the stability counter on it.
REQ-014 SHALL run a stability counter that increments while {digit, segment_data} equals the previous sample and clears on any change.
REQ-015 SHALL latch the current digit when the counter reaches STABLE_CYCLES-1, at most once per strobe dwell.
REQ-016 SHALL decode active-high glyph values 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 to nibbles 0-F; segment_data[6:0] is inverted before matching.
REQ-017 SHALL use FSM states HUNT, SETTLE, LATCH, WAIT_NEXT.
- HUNT: wait for a stable position 0.
- SETTLE: count stability.
- LATCH: write the nibble and dp into the shadow frame (1 cycle).
- WAIT_NEXT: wait for the strobe to change.
REQ-018 SHALL go from HUNT to SETTLE only when digit==8'hFE, so that frames always start at position 0.
REQ-019 SHALL expect positions in order 0→7; a stable out-of-order position SHALL discard the shadow frame and return to HUNT.
REQ-020 SHALL, on latching position 7, transfer the shadow frame to the output registers in the next cycle and set frame_valid, if frame_valid is low.
REQ-021 SHALL, if frame_valid is still high when position 7 is latched, drop the new frame, set overflow, and leave the outputs unchanged.
REQ-022 SHALL keep frame_data, frame_dp and frame_valid constant while frame_valid=1 and frame_ready=0.
REQ-023 SHALL clear frame_valid on the cycle after frame_valid&&frame_ready.
REQ-024 SHALL, when a transfer and an acceptance occur in the same cycle, accept the old frame and load the new one, leaving frame_valid=1 with no overflow.
REQ-025 SHALL have a latency of STABLE_CYCLES+2 cycles from position 7 input change to frame_valid, counting input register, settle, LATCH and transfer.

Reset
REQ-026 SHALL, on rst=1, immediately set the FSM to HUNT, the counter to 0, frame_data=0, frame_dp=0, frame_valid=0, overflow=0 and decode_err=0.
REQ-027 SHALL discard any partial frame on reset mid-frame; after release, capture restarts at the next stable position 0.

Configuration
REQ-028 SHALL, when SEG_DECODE_ERR_EN is defined, set decode_err on latching any glyph not in REQ-016; that position SHALL be stored as nibble 0 and the frame still completes.
REQ-029 SHALL, when SEG_DECODE_ERR_EN is undefined, tie decode_err to 0 and decode unrecognised glyphs to nibble 0 with no detection logic.

Verification
REQ-030 SHALL cover full frame: digit FE..7F each held 10 cycles, segments C0,F9,A4,B0,99,92,82,F8 → frame_data=32'h76543210, frame_dp=00, frame_valid=1.
REQ-031 SHALL cover glitch: digit FE with segments C0 held 2 cycles then changed, STABLE_CYCLES=4 → no latch, FSM stays in SETTLE/HUNT.
REQ-032 SHALL cover backpressure: frame_ready=0 across two complete frames → first frame held, overflow=1; frame_ready=1 → frame_valid falls next cycle.
REQ-033 SHALL cover out-of-order strobe: FE, FD, then F7 stable → shadow discarded, next valid frame from FE decodes correctly.
REQ-034 SHALL cover invalid glyph: segments 8'hFF at position 3 with SEG_DECODE_ERR_EN defined → decode_err=1, frame_data[15:12]=0; without the macro → decode_err=0.
REQ-035 SHALL cover reset mid-frame: rst pulsed after position 4 → all outputs 0, and the next complete frame is captured with no remnant nibbles.
